// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, registered read data and level flags.
// Define SYNC_FIFO_ERR_FLAG_EN to add sticky flag_overflow / flag_underflow outputs.
module sync_fifo #(
  parameter int FIFO_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_DEPTH_BIT  = 4,
  parameter int ALMOST_FULL_TH  = 14,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_en,
  input  logic [FIFO_WIDTH-1:0]   data_write,
  input  logic                    r_en,
  output logic [FIFO_WIDTH-1:0]   data_read,
  output logic                    data_valid,
  output logic                    flag_full,
  output logic                    flag_empty,
  output logic                    flag_almost_full,
  output logic                    flag_almost_empty,
`ifdef SYNC_FIFO_ERR_FLAG_EN
  output logic                    flag_overflow,
  output logic                    flag_underflow,
`endif
  output logic [FIFO_DEPTH_BIT:0] fifo_count
);
  localparam logic [FIFO_DEPTH_BIT:0] AF_TH = ALMOST_FULL_TH[FIFO_DEPTH_BIT:0];
  localparam logic [FIFO_DEPTH_BIT:0] AE_TH = ALMOST_EMPTY_TH[FIFO_DEPTH_BIT:0];
  logic [FIFO_DEPTH_BIT:0] wr_ptr, rd_ptr;
  logic [FIFO_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic                    wr_acc, rd_acc;
  // Pointer difference modulo 2*FIFO_DEPTH is the exact fill level 0..FIFO_DEPTH.
  assign fifo_count        = wr_ptr - rd_ptr;
  assign flag_empty        = wr_ptr == rd_ptr;
  assign flag_full         = (wr_ptr[FIFO_DEPTH_BIT-1:0] == rd_ptr[FIFO_DEPTH_BIT-1:0]) &&
                             (wr_ptr[FIFO_DEPTH_BIT] != rd_ptr[FIFO_DEPTH_BIT]);
  assign flag_almost_full  = fifo_count >= AF_TH;
  assign flag_almost_empty = fifo_count <= AE_TH;
  assign wr_acc            = w_en && !flag_full;
  assign rd_acc            = r_en && !flag_empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_read  <= '0;
      data_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        data_read <= mem[rd_ptr[FIFO_DEPTH_BIT-1:0]];
      end
      data_valid <= rd_acc;
    end
  end
  // Storage is deliberately left unreset; empty pointers keep stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[FIFO_DEPTH_BIT-1:0]] <= data_write;
  end
`ifdef SYNC_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
    end else begin
      if (w_en && flag_full) flag_overflow <= 1'b1;
      if (r_en && flag_empty) flag_underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table-driven fill/drain plus corner sequences and random traffic against a queue model.
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_write = 8'h00;
  logic [7:0] data_read;
  logic       data_valid, flag_full, flag_empty, flag_almost_full, flag_almost_empty;
  logic [4:0] fifo_count;
`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic       flag_overflow, flag_underflow;
`endif
  sync_fifo dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_write(data_write), .r_en(r_en),
    .data_read(data_read), .data_valid(data_valid), .flag_full(flag_full),
    .flag_empty(flag_empty), .flag_almost_full(flag_almost_full),
    .flag_almost_empty(flag_almost_empty),
`ifdef SYNC_FIFO_ERR_FLAG_EN
    .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
`endif
    .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  typedef struct {
    logic       w, r;
    logic [7:0] d;
    int         cnt;
    logic       full, empty, af, ae, valid;
    logic [7:0] dr;
  } vec_t;
  vec_t tbl[33];
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_data = 8'h00;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask
  task automatic model_step(logic w, logic r, logic [7:0] d);
    logic wa, ra;
    wa = w && (q.size() < 16);
    ra = r && (q.size() > 0);
    if (w && !wa) m_ovf = 1'b1;
    if (r && !ra) m_udf = 1'b1;
    m_valid = ra;
    if (ra) m_data = q.pop_front();
    if (wa) q.push_back(d);
  endtask
  task automatic check_model(string tag);
    int n;
    n = q.size();
    chk({tag, ".data_read"}, data_read, m_data);
    chk({tag, ".data_valid"}, data_valid, m_valid);
    chk({tag, ".count"}, fifo_count, n);
    chk({tag, ".full"}, flag_full, n == 16);
    chk({tag, ".empty"}, flag_empty, n == 0);
    chk({tag, ".almost_full"}, flag_almost_full, n >= 14);
    chk({tag, ".almost_empty"}, flag_almost_empty, n <= 2);
`ifdef SYNC_FIFO_ERR_FLAG_EN
    chk({tag, ".overflow"}, flag_overflow, m_ovf);
    chk({tag, ".underflow"}, flag_underflow, m_udf);
`endif
  endtask
  task automatic tick(logic w, logic r, logic [7:0] d, string tag);
    w_en = w;
    r_en = r;
    data_write = d;
    @(posedge clk);
    model_step(w, r, d);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
    check_model(tag);
  endtask
  initial begin
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 1'b0, 8'(i), i + 1, i == 15, 1'b0, i + 1 >= 14, i + 1 <= 2, 1'b0, 8'h00};
    for (int i = 0; i < 16; i++)
      tbl[16 + i] = '{1'b0, 1'b1, 8'h00, 15 - i, 1'b0, i == 15, 15 - i >= 14, 15 - i <= 2, 1'b1, 8'(i)};
    tbl[32] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0f};
    #12;
    model_reset();
    check_model("reset");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 33; i++) begin
      tick(tbl[i].w, tbl[i].r, tbl[i].d, "table");
      chk("tbl.count", fifo_count, tbl[i].cnt);
      chk("tbl.full", flag_full, tbl[i].full);
      chk("tbl.empty", flag_empty, tbl[i].empty);
      chk("tbl.almost_full", flag_almost_full, tbl[i].af);
      chk("tbl.almost_empty", flag_almost_empty, tbl[i].ae);
      chk("tbl.valid", data_valid, tbl[i].valid);
      if (tbl[i].valid || i == 32) chk("tbl.data", data_read, tbl[i].dr);
    end
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 8'($urandom), "fill");
    tick(1'b1, 1'b1, 8'hAA, "full_rw");
    chk("full_rw.count", fifo_count, 15);
    chk("full_rw.valid", data_valid, 1);
    tick(1'b0, 1'b0, 8'h00, "full_rw_hold");
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b1, 8'h00, "drain");
    tick(1'b0, 1'b0, 8'h00, "idle");
    tick(1'b0, 1'b1, 8'h00, "empty_rd");
    chk("empty_rd.count", fifo_count, 0);
    chk("empty_rd.valid", data_valid, 0);
    tick(1'b1, 1'b1, 8'h33, "empty_rw");
    chk("empty_rw.count", fifo_count, 1);
    chk("empty_rw.valid", data_valid, 0);
    for (int i = 0; i < 16; i++) if (q.size() < 8) tick(1'b1, 1'b0, 8'($urandom), "to8");
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b1, 8'($urandom), "steady8");
      chk("steady8.count", fifo_count, 8);
    end
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "random");
    for (int i = 0; i < 20; i++) begin
      if (q.size() > 5) tick(1'b0, 1'b1, 8'h00, "to5");
      else if (q.size() < 5) tick(1'b1, 1'b0, 8'($urandom), "to5");
    end
    chk("pre_reset.count", fifo_count, 5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_model("post_reset");
    tick(1'b1, 1'b0, 8'h5A, "wr5a");
    tick(1'b0, 1'b1, 8'h00, "rd5a");
    chk("rd5a.data", data_read, 8'h5A);
    chk("rd5a.valid", data_valid, 1);
    tick(1'b0, 1'b0, 8'h00, "end");
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8: data word width in bits, legal 1..256.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: number of storage words, power of two, legal 2..1024.
REQ-003 SHALL have parameter FIFO_DEPTH_BIT, default 4: log2(FIFO_DEPTH); any mismatch with FIFO_DEPTH is a configuration error.
REQ-004 SHALL have parameter ALMOST_FULL_TH, default 14: fill level at or above which almost-full asserts, legal 1..FIFO_DEPTH.
REQ-005 SHALL have parameter ALMOST_EMPTY_TH, default 2: fill level at or below which almost-empty asserts, legal 0..FIFO_DEPTH-1.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port w_en, input, 1: write request.
REQ-009 SHALL have port data_write, input, FIFO_WIDTH: write data, sampled with w_en.
REQ-010 SHALL have port r_en, input, 1: read request.
REQ-011 SHALL have port data_read, output, FIFO_WIDTH: registered read data.
REQ-012 SHALL have port data_valid, output, 1: data_read holds a newly popped word this cycle.
REQ-013 SHALL have port flag_full, output, 1: fill level == FIFO_DEPTH.
REQ-014 SHALL have port flag_empty, output, 1: fill level == 0.
REQ-015 SHALL have port flag_almost_full, output, 1: fill level >= ALMOST_FULL_TH.
REQ-016 SHALL have port flag_almost_empty, output, 1: fill level <= ALMOST_EMPTY_TH.
REQ-017 SHALL have port fifo_count, output, FIFO_DEPTH_BIT+1: current fill level, 0..FIFO_DEPTH.

Function
REQ-018 Write SHALL be accepted iff w_en=1 and flag_full=0; the accepted word goes to memory[write_addr] and write_addr increments modulo FIFO_DEPTH.
REQ-019 Read SHALL be accepted iff r_en=1 and flag_empty=0; data_read loads memory[read_addr] at that edge and read_addr increments modulo FIFO_DEPTH.
REQ-020 Read latency SHALL be one cycle: data_valid=1 in the cycle after an accepted read, else 0.
REQ-021 data_read SHALL hold its last value when no read is accepted.
REQ-022 Simultaneous accepted read and write SHALL leave fifo_count unchanged; accepted write alone adds 1, accepted read alone subtracts 1.
REQ-023 When full with w_en=1 and r_en=1, only the read SHALL be accepted; count drops to FIFO_DEPTH-1.
REQ-024 When empty with w_en=1 and r_en=1, only the write SHALL be accepted; no bypass; data_valid stays 0.
REQ-025 Internal pointers SHALL be FIFO_DEPTH_BIT+1 bits, the MSB a wrap bit; full = address bits equal and wrap bits differ; empty = pointers equal.
REQ-026 All flags and fifo_count SHALL be functions of registered state only, updated in the same edge as the accepted operation.
REQ-027 Rejected requests (write when full, read when empty) SHALL change no state other than the error flags of REQ-032.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, clear both pointers and fifo_count to 0, data_read to 0, data_valid to 0.
REQ-029 During reset flag_empty=1, flag_almost_empty=1, flag_full=0, flag_almost_full=0 (ALMOST_FULL_TH>=1).
REQ-030 Memory contents SHALL NOT be reset; no word is readable until written.
REQ-031 Reset asserted mid-operation SHALL discard all stored words; the first accepted write after release is the first word read.

Configuration
REQ-032 With macro SYNC_FIFO_ERR_FLAG_EN defined, SHALL add outputs flag_overflow and flag_underflow (1 bit each), set sticky on a rejected write / rejected read respectively, cleared only by rst_n=0.
REQ-033 Without SYNC_FIFO_ERR_FLAG_EN, those ports and their registers SHALL not exist; all other behaviour identical.

Verification
REQ-034 Reset, then 16 writes 0x00..0x0F (defaults) -> flag_full=1, fifo_count=16, flag_almost_full asserted from count 14.
REQ-035 Then 16 reads -> data_read 0x00..0x0F in order, each with data_valid one cycle after r_en, flag_empty=1 after the last.
REQ-036 Full FIFO, w_en=r_en=1 with data 0xAA -> read accepted, write dropped, count=15; with ERR_FLAG_EN, flag_overflow=1 and stays 1.
REQ-037 Empty FIFO, r_en=1 -> data_read unchanged, data_valid=0, count=0; with ERR_FLAG_EN, flag_underflow=1.
REQ-038 Count held at 8, continuous simultaneous read/write for 40 cycles -> count stays 8, pointers wrap past 15, data order preserved.
REQ-039 rst_n pulsed low mid-clock with count=5 -> outputs cleared before next clk edge; subsequent write 0x5A then read returns 0x5A.
